// File: rtl/small_filters_pkg.sv
`default_nettype none
// ============================================================================
// Package : small_filters_pkg
// Brief   : Shared types and helpers for the small filter / oscillator family:
//           oscillator state encoding and a width-generic saturating adder.
// Rev     : 1.0  initial release
// ============================================================================
package small_filters_pkg;

  // Oscillator control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEED  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } osc_state_t;

  // Adds two sign-extended operands and saturates the sum to a signed range
  // of w bits. The caller narrows the 64-bit return value to w bits; sat
  // reports that the true sum did not fit.
  function automatic logic signed [63:0] sat_add(
    input  logic signed [63:0] a,
    input  logic signed [63:0] b,
    input  int                 w,
    output logic               sat
  );
    logic signed [63:0] sum;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] res;
    sum = a + b;
    hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo  = -hi - 64'sd1;
    sat = 1'b0;
    res = sum;
    if (sum > hi) begin
      res = hi;
      sat = 1'b1;
    end else if (sum < lo) begin
      res = lo;
      sat = 1'b1;
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/small_quad_osc_if.sv
`default_nettype none
// ============================================================================
// Interface : small_quad_osc_if
// Brief     : Valid/ready sample-pair stream of the quadrature oscillator.
//             master = producer (oscillator), slave = consumer.
// Rev       : 1.0  initial release
// ============================================================================
interface small_quad_osc_if #(
  parameter int WIDTH = 16
) ();

  logic signed [WIDTH-1:0] sinOut;
  logic signed [WIDTH-1:0] cosOut;
  logic                    outValid;
  logic                    outReady;
  logic                    zeroCross;

  modport master (
    output sinOut,
    output cosOut,
    output outValid,
    output zeroCross,
    input  outReady
  );

  modport slave (
    input  sinOut,
    input  cosOut,
    input  outValid,
    input  zeroCross,
    output outReady
  );

endinterface
`default_nettype wire

// File: rtl/small_osc_core.sv
`default_nettype none
// ============================================================================
// Module : small_osc_core
// Brief  : Magic-circle rotation datapath: cosine/sine accumulators, one
//          shift-only rotation step, optional accumulator saturation.
// Config : SMALL_QUAD_OSC_CLAMP_EN defined   -> accumulators saturate
//          SMALL_QUAD_OSC_CLAMP_EN undefined -> accumulators wrap
// Rev    : 1.0  initial release
// ============================================================================
module small_osc_core #(
  parameter int FREQ_SHIFT = 8,
  parameter int WIDTH      = 16
) (
  input  wire                     clk,
  input  wire                     rst,
  input  wire                     i_clear,
  input  wire                     i_seed,
  input  wire                     i_step,
  input  wire        [WIDTH-1:0]  i_amp,
  output logic signed [WIDTH-1:0] o_cos_smp,
  output logic signed [WIDTH-1:0] o_sin_smp,
  output logic                    o_zero_cross,
  output logic                    o_clamp
);
  import small_filters_pkg::*;

  localparam int c_ACC_W = WIDTH + FREQ_SHIFT;

  logic signed [c_ACC_W-1:0] r_c_acc;
  logic signed [c_ACC_W-1:0] r_s_acc;
  logic signed [c_ACC_W-1:0] w_s_shr;
  logic signed [c_ACC_W-1:0] w_c_next;
  logic signed [c_ACC_W-1:0] w_c_shr;
  logic signed [c_ACC_W-1:0] w_s_next;
  logic                      w_c_sat;
  logic                      w_s_sat;

  // Rotation step: cosine first, then sine from the updated cosine.
  always_comb begin
    w_c_sat = 1'b0;
    w_s_sat = 1'b0;
    w_s_shr = r_s_acc >>> FREQ_SHIFT;
`ifdef SMALL_QUAD_OSC_CLAMP_EN
    w_c_next = c_ACC_W'(sat_add(64'(r_c_acc), -64'(w_s_shr), c_ACC_W, w_c_sat));
    w_c_shr  = w_c_next >>> FREQ_SHIFT;
    w_s_next = c_ACC_W'(sat_add(64'(r_s_acc), 64'(w_c_shr), c_ACC_W, w_s_sat));
`else
    // Wrapping result is just the low bits of the wide sum.
    w_c_next = c_ACC_W'(64'(r_c_acc) - 64'(w_s_shr));
    w_c_shr  = w_c_next >>> FREQ_SHIFT;
    w_s_next = c_ACC_W'(64'(r_s_acc) + 64'(w_c_shr));
`endif
  end

  // Accumulator register: clear beats seed beats step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_c_acc <= '0;
      r_s_acc <= '0;
    end else if (i_clear) begin
      r_c_acc <= '0;
      r_s_acc <= '0;
    end else if (i_seed) begin
      r_c_acc <= $signed({i_amp, {FREQ_SHIFT{1'b0}}});
      r_s_acc <= '0;
    end else if (i_step) begin
      r_c_acc <= w_c_next;
      r_s_acc <= w_s_next;
    end
  end

  // Samples are the accumulators with the fractional guard bits dropped.
  assign o_cos_smp    = w_c_next[c_ACC_W-1:FREQ_SHIFT];
  assign o_sin_smp    = w_s_next[c_ACC_W-1:FREQ_SHIFT];
  assign o_zero_cross = r_s_acc[c_ACC_W-1] & ~w_s_next[c_ACC_W-1];
  assign o_clamp      = i_step & (w_c_sat | w_s_sat);

endmodule
`default_nettype wire

// File: rtl/small_quad_osc.sv
`default_nettype none
// ============================================================================
// Module : small_quad_osc
// Brief  : Shift-only quadrature sine/cosine generator. One rotation step per
//          accepted en strobe, sample pairs on a valid/ready stream, with
//          start/stop control, amplitude seeding and zero-crossing marks.
// Config : SMALL_QUAD_OSC_CLAMP_EN -> saturating accumulators, clampFlag live
// Rev    : 1.0  initial release
// ============================================================================
module small_quad_osc #(
  parameter int FREQ_SHIFT = 8,
  parameter int WIDTH      = 16
) (
  input  wire               clk,
  input  wire               rst,
  input  wire               en,
  input  wire               start,
  input  wire               stop,
  input  wire  [WIDTH-1:0]  amp,
  small_quad_osc_if.master  osc_if,
  output logic              running,
  output logic              overrun,
  output logic              clampFlag
);
  import small_filters_pkg::*;

  osc_state_t              r_state;
  osc_state_t              w_state_next;
  logic                    w_step;
  logic                    w_accept;
  logic                    w_drop;
  logic                    w_enter_idle;
  logic                    w_enter_seed;
  logic signed [WIDTH-1:0] w_cos_smp;
  logic signed [WIDTH-1:0] w_sin_smp;
  logic                    w_zc;
  logic                    w_clamp_pulse;
  logic signed [WIDTH-1:0] r_cos;
  logic signed [WIDTH-1:0] r_sin;
  logic                    r_zc;
  logic                    r_valid;
  logic                    r_overrun;
  logic                    r_clamp;

  // A strobe steps only in RUN and only if the output slot is free this cycle.
  assign w_accept     = r_valid & osc_if.outReady;
  assign w_step       = (r_state == RUN) & en & (~r_valid | osc_if.outReady);
  assign w_drop       = (r_state == RUN) & en & r_valid & ~osc_if.outReady;
  assign w_enter_idle = (r_state != IDLE) & (w_state_next == IDLE);
  assign w_enter_seed = (r_state != SEED) & (w_state_next == SEED);

  small_osc_core #(
    .FREQ_SHIFT (FREQ_SHIFT),
    .WIDTH      (WIDTH)
  ) u_core (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (w_enter_idle),
    .i_seed       (r_state == SEED),
    .i_step       (w_step),
    .i_amp        (amp),
    .o_cos_smp    (w_cos_smp),
    .o_sin_smp    (w_sin_smp),
    .o_zero_cross (w_zc),
    .o_clamp      (w_clamp_pulse)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_next;
  end

  // Next-state logic; stop wins over start, DRAIN ignores start.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = SEED;
      SEED:    w_state_next = stop ? DRAIN : RUN;
      RUN: begin
        if (stop)       w_state_next = DRAIN;
        else if (start) w_state_next = SEED;
      end
      DRAIN:   if (!r_valid || osc_if.outReady) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Output pair register: loads on a step, empties on a bare accept,
  // and is zeroed whenever the oscillator falls back to IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cos   <= '0;
      r_sin   <= '0;
      r_zc    <= 1'b0;
      r_valid <= 1'b0;
    end else if (w_enter_idle) begin
      r_cos   <= '0;
      r_sin   <= '0;
      r_zc    <= 1'b0;
      r_valid <= 1'b0;
    end else if (w_step) begin
      r_cos   <= w_cos_smp;
      r_sin   <= w_sin_smp;
      r_zc    <= w_zc;
      r_valid <= 1'b1;
    end else if (w_accept) begin
      r_valid <= 1'b0;
    end
  end

  // Sticky flags, cleared when a new seed begins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overrun <= 1'b0;
      r_clamp   <= 1'b0;
    end else if (w_enter_seed) begin
      r_overrun <= 1'b0;
      r_clamp   <= 1'b0;
    end else begin
      if (w_drop)        r_overrun <= 1'b1;
      if (w_clamp_pulse) r_clamp   <= 1'b1;
    end
  end

  assign osc_if.cosOut    = r_cos;
  assign osc_if.sinOut    = r_sin;
  assign osc_if.zeroCross = r_zc;
  assign osc_if.outValid  = r_valid;
  assign running          = (r_state == SEED) | (r_state == RUN);
  assign overrun          = r_overrun;
`ifdef SMALL_QUAD_OSC_CLAMP_EN
  assign clampFlag        = r_clamp;
`else
  assign clampFlag        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_small_quad_osc.sv
`default_nettype none
// ============================================================================
// Module : tb_small_quad_osc
// Brief  : Self-checking bench for small_quad_osc: scoreboard of hand-computed
//          sample pairs plus directed control, backpressure and long-run tests.
// Rev    : 1.0  initial release
// ============================================================================
module tb_small_quad_osc;

  typedef struct {
    int s;
    int c;
  } pair_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0, start = 1'b0, stop = 1'b0;
  logic [15:0] amp = 16'd0;
  logic        running, overrun, clampFlag;

  logic        en2 = 1'b0, start2 = 1'b0, stop2 = 1'b0;
  logic [15:0] amp2 = 16'd32767;
  logic        running2, overrun2, clampFlag2;

  int    n_tests = 0;
  int    n_fail  = 0;
  bit    sb_on   = 1'b0;
  pair_t sb_q[$];
  pair_t exp_p;

  small_quad_osc_if #(.WIDTH(16)) osc  ();
  small_quad_osc_if #(.WIDTH(16)) osc2 ();

  small_quad_osc #(.FREQ_SHIFT(8), .WIDTH(16)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .stop(stop), .amp(amp),
    .osc_if(osc), .running(running), .overrun(overrun), .clampFlag(clampFlag)
  );

  small_quad_osc #(.FREQ_SHIFT(2), .WIDTH(16)) dut2 (
    .clk(clk), .rst(rst), .en(en2), .start(start2), .stop(stop2), .amp(amp2),
    .osc_if(osc2), .running(running2), .overrun(overrun2), .clampFlag(clampFlag2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_tests++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic push(input int s, input int c);
    sb_q.push_back('{s: s, c: c});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Scoreboard monitor: every accepted pair must match the queue head.
  always @(negedge clk) begin
    if (sb_on && rst && osc.outValid && osc.outReady) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: got pair sin=%0d cos=%0d, expected none",
                 osc.sinOut, osc.cosOut);
      end else begin
        exp_p = sb_q.pop_front();
        check("sb_sin", osc.sinOut, exp_p.s);
        check("sb_cos", osc.cosOut, exp_p.c);
      end
    end
  end

  int k, last_zc, n_iv, iv, pk_s, pk_c, a_s, a_c, prev_s;
  bit have_zc, have_prev;

  initial begin
    osc.outReady  = 1'b1;
    osc2.outReady = 1'b1;

    // Reset values
    repeat (3) cyc();
    mid();
    check("rst_sin", osc.sinOut, 0);
    check("rst_cos", osc.cosOut, 0);
    check("rst_valid", osc.outValid, 0);
    check("rst_zc", osc.zeroCross, 0);
    check("rst_running", running, 0);
    check("rst_overrun", overrun, 0);
    check("rst_clamp", clampFlag, 0);
    cyc();
    rst = 1'b1;
    cyc();

    // First pairs after seeding amp=16384
    sb_on = 1'b1;
    push(64, 16384);
    push(127, 16383);
    push(191, 16383);
    push(255, 16382);
    push(319, 16381);
    push(383, 16380);
    amp   = 16'd16384;
    start = 1'b1;
    cyc();
    start = 1'b0;
    mid();
    check("running_seed", running, 1);
    cyc();
    en = 1'b1;
    repeat (6) cyc();
    en = 1'b0;
    repeat (2) cyc();
    mid();
    check("sb_empty_1", sb_q.size(), 0);
    check("running_run", running, 1);

    // Backpressure: held pair, overrun, release steps exactly once more
    cyc();
    osc.outReady = 1'b0;
    en = 1'b1;
    push(447, 16378);
    cyc();
    for (int i = 0; i < 5; i++) begin
      mid();
      check("hold_sin", osc.sinOut, 447);
      check("hold_cos", osc.cosOut, 16378);
      check("hold_valid", osc.outValid, 1);
      cyc();
    end
    mid();
    check("overrun_set", overrun, 1);
    cyc();
    push(511, 16377);
    osc.outReady = 1'b1;
    mid();
    cyc();
    en = 1'b0;
    mid();
    cyc();

    // Stop while a pair is held, accepted after 3 cycles
    osc.outReady = 1'b0;
    en = 1'b1;
    push(575, 16375);
    cyc();
    en   = 1'b0;
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mid();
      check("drain_running", running, 0);
      check("drain_valid", osc.outValid, 1);
      cyc();
    end
    osc.outReady = 1'b1;
    mid();
    cyc();
    mid();
    check("idle_sin", osc.sinOut, 0);
    check("idle_cos", osc.cosOut, 0);
    check("idle_valid", osc.outValid, 0);
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      mid();
      check("idle_strobe_valid", osc.outValid, 0);
      check("idle_strobe_sin", osc.sinOut, 0);
    end
    cyc();
    en = 1'b0;
    check("sb_empty_2", sb_q.size(), 0);

    // start+stop together in RUN: stop wins, no reseed
    start = 1'b1;
    cyc();
    start = 1'b0;
    mid();
    check("overrun_clr_seed", overrun, 0);
    cyc();
    start = 1'b1;
    stop  = 1'b1;
    cyc();
    start = 1'b0;
    stop  = 1'b0;
    mid();
    check("startstop_running_1", running, 0);
    cyc();
    mid();
    check("startstop_running_2", running, 0);
    cyc();

    // Long continuous run: zero-cross spacing and amplitude
    sb_on = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    en = 1'b1;
    k = 0; n_iv = 0; have_zc = 1'b0; pk_s = 0; pk_c = 0;
    for (int i = 0; i < 35000; i++) begin
      mid();
      if (osc.outValid) begin
        k++;
        a_s = (osc.sinOut < 0) ? -int'(osc.sinOut) : int'(osc.sinOut);
        a_c = (osc.cosOut < 0) ? -int'(osc.cosOut) : int'(osc.cosOut);
        if (a_s > pk_s) pk_s = a_s;
        if (a_c > pk_c) pk_c = a_c;
        if (osc.zeroCross) begin
          if (have_zc && n_iv < 20) begin
            iv = k - last_zc;
            check_range("zc_interval", iv, 1607, 1610);
            n_iv++;
          end
          have_zc = 1'b1;
          last_zc = k;
        end
      end
      cyc();
    end
    en = 1'b0;
    check("zc_interval_count", n_iv, 20);
    check_range("peak_sin", pk_s, 16384 - 128, 16384 + 128);
    check_range("peak_cos", pk_c, 16384 - 128, 16384 + 128);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    repeat (3) cyc();
    mid();
    check("main_clamp", clampFlag, 0);
    check("main_stopped", running, 0);
    cyc();

    // Large amplitude with a coarse step: saturation behaviour
    start2 = 1'b1;
    cyc();
    start2 = 1'b0;
    cyc();
    en2 = 1'b1;
    have_prev = 1'b0;
    prev_s = 0;
    for (int i = 0; i < 80; i++) begin
      mid();
      if (osc2.outValid) begin
`ifdef SMALL_QUAD_OSC_CLAMP_EN
        if (have_prev)
          check_range("clamp_sin_step", int'(osc2.sinOut) - prev_s, -16383, 16383);
`endif
        prev_s    = int'(osc2.sinOut);
        have_prev = 1'b1;
      end
      cyc();
    end
    en2 = 1'b0;
    mid();
`ifdef SMALL_QUAD_OSC_CLAMP_EN
    check("clamp_flag_set", clampFlag2, 1);
`else
    check("clamp_flag_tied", clampFlag2, 0);
`endif
    check("dut2_running", running2, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/small_quad_osc.md
# small_quad_osc

Shift-only quadrature sine/cosine generator built on the same adder-and-shift accumulator style as the small filter blocks. It produces a band-limited test tone or local-oscillator source that can drive the small low-pass filters. It runs one "magic-circle" rotation step per `en` strobe and presents each sample pair on a valid/ready output stream. Start and stop control, runtime amplitude seeding, and zero-crossing marking make it usable as a stimulus source and as a modulator carrier.

## Interface
- `FREQ_SHIFT`, 8: rotation step is 2^-FREQ_SHIFT rad per strobe; period ≈ 2π·2^FREQ_SHIFT strobes.
- `WIDTH`, 16: sample width; the accumulators are WIDTH+FREQ_SHIFT bits signed.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  rotation strobe; one step per accepted strobe.
- `start`  in  1  pulse; seeds the oscillator and begins running.
- `stop`  in  1  pulse; ends running after the pending sample drains.
- `amp`  in  WIDTH  unsigned seed amplitude; sampled only in SEED; valid range is 0..2^(WIDTH-1)-1.
- `sinOut`  out  WIDTH  signed sine sample.
- `cosOut`  out  WIDTH  signed cosine sample.
- `outValid`  out  1  sample pair valid.
- `outReady`  in  1  consumer accepts the pair when `outValid && outReady`.
- `zeroCross`  out  1  sideband of the current pair; 1 when sin went from negative to ≥0 on this step.
- `running`  out  1  high in SEED and RUN.
- `overrun`  out  1  sticky; an `en` strobe was dropped because of backpressure.
- `clampFlag`  out  1  sticky; an accumulator saturated.

## Operation
- States:
  - **IDLE**: accumulators are 0; strobes are ignored.
  - **SEED**: one cycle; cAcc ← amp<<<FREQ_SHIFT, sAcc ← 0.
  - **RUN**: steps on strobes.
  - **DRAIN**: waits for the held pair to be accepted.
- Transitions:
  - IDLE→SEED on `start`.
  - SEED→RUN unconditionally.
  - RUN→SEED on `start` (reseed). A held pair stays valid until it is accepted.
  - RUN or SEED→DRAIN on `stop`.
  - DRAIN→IDLE when `outValid` is 0 or is accepted this cycle. Accumulators are zeroed on entry to IDLE.
  - Simultaneous `start` and `stop`: `stop` wins. `start` during DRAIN is ignored.
- Step, taken in RUN when `en && (!outValid || outReady)`:
  - cNext = cAcc − (sAcc>>>FREQ_SHIFT)
  - sNext = sAcc + (cNext>>>FREQ_SHIFT), using the updated cosine.
  - Arithmetic uses arithmetic shifts and is computed one bit wider than the accumulator.
- Output register loads on every step:
  - `cosOut` = cNext>>>FREQ_SHIFT, `sinOut` = sNext>>>FREQ_SHIFT.
  - `zeroCross` = (old sin sample < 0) && (new sin sample ≥ 0).
  - `outValid` ← 1.
- Backpressure:
  - `en` with `outValid && !outReady` performs no step and sets `overrun`.
  - An accepted pair with no step in the same cycle clears `outValid`.
- The held pair is stable while `outValid && !outReady`.
- Clearing the sticky flags:
  - `overrun` and `clampFlag` clear only on reset or on entry to SEED.

## Timing
- Reset values:
  - `sinOut`, `cosOut`: 0.
  - `outValid`, `zeroCross`, `running`, `overrun`, `clampFlag`: 0.
  - State: IDLE.
- `start` at cycle n: SEED during n+1, RUN from n+2.
- The first strobe eligible is at cycle ≥ n+2. A strobe at cycle m gives `outValid` high at m+1. Latency is 1 cycle from strobe to sample.
- A pair accepted in cycle m while a strobe also arrives in cycle m: the new pair is valid at m+1, so full throughput is one pair per cycle.
- `stop` at cycle n with nothing pending: IDLE at n+2 and `running` low at n+1.
- `stop` while a pair is held: IDLE on the cycle after acceptance.
- Reset asserted mid-operation: everything returns to reset values immediately, with no drain.

## Configuration
- `SMALL_QUAD_OSC_CLAMP_EN` defined:
  - Each accumulator update saturates to the accumulator range when the top two bits of the wide result differ.
  - Saturation sets `clampFlag`.
- `SMALL_QUAD_OSC_CLAMP_EN` undefined:
  - Accumulators wrap two's-complement.
  - `clampFlag` is tied to 0.

## Structure
- Shared package `small_filters_pkg` holds:
  - the state enum (IDLE, SEED, RUN, DRAIN);
  - a saturating-add function parameterised by width, also reused by the filters.
- One sub-module, `small_osc_core`: the two accumulators, the step arithmetic and the optional clamp.
- The top level holds the FSM, the output register, the handshake and the flags.

## Test plan
- Reset, then `start` with `amp`=16384, WIDTH=16, FREQ_SHIFT=8, `en` every cycle, `outReady`=1:
  - first pair is `cosOut`=16384, `sinOut`=64;
  - `running`=1.
- Continuous run as above:
  - intervals between `zeroCross` pulses are 1607–1610 strobes;
  - |sin| and |cos| peak within 16384±128 for 20 periods.
- `outReady`=0 for 5 cycles with `en`=1:
  - pair holds stable;
  - `overrun`=1;
  - on release, the next pair is exactly one step beyond the held pair.
- `stop` while a pair is held, then `outReady` after 3 cycles:
  - IDLE one cycle after acceptance;
  - outputs become 0 and stay 0 under further strobes.
- `start` and `stop` in the same cycle during RUN:
  - FSM goes to DRAIN, with no reseed.
- With the macro defined, `amp`=32767 and FREQ_SHIFT=2:
  - `clampFlag` sets and outputs stay within ±32767/−32768 with no sign flip;
  - with the macro undefined, `clampFlag` stays 0.
